multicycle_ctrl: RTL

Sequencing controller for the execute datapath: owns the PC and instruction register. Steps each instruction through fetch, decode, execute, memory and write-back over several clocks using ready/req handshakes to instruction and data memory. Consumes the decoder control bits and the ALU zero flag. Emits the qualified register-file write strobe and memory strobes so the single-cycle datapath becomes a multi-cycle processor.

---
 rtl/multicycle_ctrl_pkg.sv | 20 ++
 rtl/multicycle_ctrl_if.sv | 24 ++
 rtl/multicycle_ctrl_next_pc.sv | 28 ++
 rtl/multicycle_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_ctrl_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction- and data-memory request/ready bundle between controller and memories.
// Latency: combinational wires.
// Backpressure: each req holds until its ready is sampled high.
interface multicycle_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ready, imem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ready, imem_rdata, dmem_ready
    );

endinterface

// File: rtl/multicycle_ctrl_next_pc.sv
// Next-PC selection: jump target beats taken branch beats pc+4.
// Latency: combinational.
// Backpressure: none.
module next_pc_unit (
    input  logic [31:0] pc,
    input  logic [25:0] instr_idx,
    input  logic [31:0] imm32,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr_idx, 2'b00};
        end else if (branch && zero) begin
            // Word offset; the top two bits fall off, giving modulo-2^32 arithmetic.
            next_pc = pc_plus4 + {imm32[29:0], 2'b00};
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer owning pc/instr: FETCH, DECODE, EXEC, MEM, WB, HALT.
// Latency: 3-5 cycles per instruction with zero-wait memories, +1 per ready wait cycle.
// Backpressure: FETCH/MEM stall with req held high until the matching ready is seen.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic                    CLK,
    input  logic                    RST,
    multicycle_ctrl_if.master       bus,
    output logic [31:0]             instr,
    output logic [31:0]             pc,
    input  logic                    reg_write,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic                    jump,
    input  logic                    branch,
    input  logic                    zero,
    input  logic [31:0]             imm32,
    output logic                    reg_we,
    output logic [ST_W-1:0]         state,
    output logic                    halted,
    output logic [31:0]             instr_count
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, instr_q, count_q;
    logic [31:0] next_pc;
    logic        load_instr, retire;

    next_pc_unit u_next_pc (
        .pc        (pc_q),
        .instr_idx (instr_q[25:0]),
        .imm32     (imm32),
        .jump      (jump),
        .branch    (branch),
        .zero      (zero),
        .next_pc   (next_pc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_instr) begin
                instr_q <= bus.imem_rdata;
            end
            if (retire) begin
                pc_q    <= next_pc;
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        load_instr = 1'b0;
        retire     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    load_instr = 1'b1;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = (instr_q == HALT_WORD) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (mem_read || mem_write) begin
                    state_d = ST_MEM;
                end else if (reg_write) begin
                    state_d = ST_WB;
                end else begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (bus.dmem_ready) begin
                    if (mem_read) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State already sits at FETCH during reset, so the fetch strobe needs explicit gating.
    assign bus.imem_req  = (state_q == ST_FETCH) && !RST;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_req  = (state_q == ST_MEM);
    assign bus.dmem_we   = (state_q == ST_MEM) && mem_write;
    assign reg_we        = (state_q == ST_WB);
    assign halted        = (state_q == ST_HALT);
    assign state         = state_q;
    assign pc            = pc_q;
    assign instr         = instr_q;
    assign instr_count   = count_q;

endmodule
